// File: rtl/nios_multi_timer_pkg.sv
// nios_multi_timer_pkg: register offsets, bit indices and bus width shared by the multi-channel timer.
package nios_multi_timer_pkg;
  localparam int DATA_W = 32;
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAPSHOT = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam int ST_TO    = 0;
  localparam int ST_RUN   = 1;
  localparam int CT_ITO   = 0;
  localparam int CT_CONT  = 1;
  localparam int CT_START = 2;
  localparam int CT_STOP  = 3;
  localparam int CT_CASC  = 4;
endpackage

// File: rtl/nios_multi_timer_channel.sv
// nios_multi_timer_channel: one prescaled down-counter with period, snapshot and timeout status.
// CONTROL bit4 CASC exists only when NIOS_MULTI_TIMER_CASCADE_EN is defined.
module nios_multi_timer_channel
  import nios_multi_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 16,
  parameter int RESET_PERIOD = 499,
  parameter bit CASC_OK      = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr,
  input  logic [2:0]        i_reg,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ext_tick,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_irq,
  output logic              o_tmo
);
  logic [CNT_W-1:0] r_cnt, r_period, r_snap;
  logic [PRE_W-1:0] r_pre, r_pcnt;
  logic r_ito, r_cont, r_to, r_run;
  logic w_casc, w_tick, w_wr_st, w_wr_ctl, w_wr_per, w_wr_snap, w_wr_pre;
  logic [DATA_W-1:0] w_status, w_control;
  logic w_unused;

  assign w_wr_st   = i_wr && i_reg == REG_STATUS;
  assign w_wr_ctl  = i_wr && i_reg == REG_CONTROL;
  assign w_wr_per  = i_wr && i_reg == REG_PERIOD;
  assign w_wr_snap = i_wr && i_reg == REG_SNAPSHOT;
  assign w_wr_pre  = i_wr && i_reg == REG_PRESCALE;
  assign w_unused  = ^{i_wdata, i_ext_tick};

`ifdef NIOS_MULTI_TIMER_CASCADE_EN
  logic r_casc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_casc <= 1'b0;
    else if (w_wr_ctl) r_casc <= CASC_OK && i_wdata[CT_CASC];
  assign w_casc = r_casc;
`else
  assign w_casc = 1'b0;
`endif

  // a cascaded channel counts the previous channel's timeouts instead of prescaler ticks
  assign w_tick = r_run && (w_casc ? i_ext_tick : r_pcnt == '0);
  assign o_tmo  = w_tick && r_cnt == '0;
  assign o_irq  = r_to && r_ito;

  // register writes come last so they override the counting updates in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= CNT_W'(RESET_PERIOD);
      r_period <= CNT_W'(RESET_PERIOD);
      r_snap   <= '0;
      r_pre    <= '0;
      r_pcnt   <= '0;
      r_ito    <= 1'b0;
      r_cont   <= 1'b0;
      r_to     <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      if (r_run && !w_casc) r_pcnt <= r_pcnt == '0 ? r_pre : r_pcnt - 1'b1;
      if (w_tick) r_cnt <= o_tmo ? r_period : r_cnt - 1'b1;
      if (o_tmo && !r_cont) r_run <= 1'b0;
      r_to <= o_tmo || (r_to && !w_wr_st);
      if (w_wr_ctl) begin
        r_ito  <= i_wdata[CT_ITO];
        r_cont <= i_wdata[CT_CONT];
        if (i_wdata[CT_START]) r_run <= 1'b1;
        else if (i_wdata[CT_STOP]) r_run <= 1'b0;
      end
      if (w_wr_per) begin
        r_period <= i_wdata[CNT_W-1:0];
        r_cnt    <= i_wdata[CNT_W-1:0];
        r_run    <= 1'b0;
        r_pcnt   <= '0;
      end
      if (w_wr_snap) r_snap <= r_cnt;
      if (w_wr_pre) r_pre <= i_wdata[PRE_W-1:0];
    end
  end

  always_comb begin
    w_status = '0;
    w_status[ST_TO] = r_to;
    w_status[ST_RUN] = r_run;
    w_control = '0;
    w_control[CT_ITO] = r_ito;
    w_control[CT_CONT] = r_cont;
    w_control[CT_CASC] = w_casc;
  end

  assign o_rdata = i_reg == REG_STATUS   ? w_status :
                   i_reg == REG_CONTROL  ? w_control :
                   i_reg == REG_PERIOD   ? DATA_W'(r_period) :
                   i_reg == REG_SNAPSHOT ? DATA_W'(r_snap) :
                   i_reg == REG_PRESCALE ? DATA_W'(r_pre) : '0;
endmodule

// File: rtl/nios_multi_timer.sv
// nios_multi_timer: NUM_CH interval timers behind an Avalon-MM slave with registered reads and irq vector.
// Channel-to-channel cascading is enabled by defining NIOS_MULTI_TIMER_CASCADE_EN.
module nios_multi_timer
  import nios_multi_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 16,
  parameter int RESET_PERIOD = 499
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [$clog2(NUM_CH)+2:0]  address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [DATA_W-1:0]          writedata,
  output logic [DATA_W-1:0]          readdata,
  output logic                       irq,
  output logic [NUM_CH-1:0]          irq_vec
);
  localparam int AW = $clog2(NUM_CH) + 3;

  logic w_wr;
  logic [AW-1:0] w_ch;
  logic [NUM_CH-1:0] w_sel, w_tmo, w_ext;
  logic [DATA_W-1:0] w_rd [NUM_CH];
  logic [DATA_W-1:0] w_rdata;
  logic w_unused;

  assign w_wr = chipselect && !write_n;
  assign w_ch = address >> 3;
  assign w_unused = w_tmo[NUM_CH-1];

  // out-of-range channel numbers match no w_sel bit, so they neither write nor read
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_sel[g] = w_ch == AW'(g);
    if (g == 0) begin : g_head
      assign w_ext[g] = 1'b0;
    end else begin : g_link
      assign w_ext[g] = w_tmo[g-1];
    end
    nios_multi_timer_channel #(
      .CNT_W(CNT_W),
      .PRE_W(PRE_W),
      .RESET_PERIOD(RESET_PERIOD),
      .CASC_OK(g > 0)
    ) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .i_wr(w_wr && w_sel[g]),
      .i_reg(address[2:0]),
      .i_wdata(writedata),
      .i_ext_tick(w_ext[g]),
      .o_rdata(w_rd[g]),
      .o_irq(irq_vec[g]),
      .o_tmo(w_tmo[g])
    );
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) w_rdata = w_sel[i] ? w_rd[i] : w_rdata;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= w_rdata;

  assign irq = |irq_vec;
endmodule

// File: tb/tb_nios_multi_timer.sv
// tb_nios_multi_timer: scoreboard bench; reads queue their expected value, a monitor compares registered readdata.
module tb_nios_multi_timer;
  localparam int NUM_CH = 4;
  localparam int AW = $clog2(NUM_CH) + 3;

  logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1;
  logic [AW-1:0] address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic irq;
  logic [NUM_CH-1:0] irq_vec;
  logic rd_req = 1'b0, rd_vld = 1'b0;
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  string name_q[$];

  nios_multi_timer #(.NUM_CH(NUM_CH), .CNT_W(32), .PRE_W(16), .RESET_PERIOD(499)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow got=0x%0h want=queued_entry", readdata);
      end else begin
        logic [31:0] e;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        if (readdata !== e) begin
          bad++;
          $display("FAIL %s got=0x%0h want=0x%0h", nm, readdata, e);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", nm, got, want);
    end
  endtask

  task automatic wr(input int ch, input int r, input int unsigned d);
    address = AW'(ch * 8 + r);
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input int ch, input int r, input int unsigned want, input string nm);
    address = AW'(ch * 8 + r);
    chipselect = 1'b1;
    rd_req = 1'b1;
    exp_q.push_back(want);
    name_q.push_back(nm);
    @(negedge clk);
    rd_req = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic wait_irq(input int ch, input int lim, output int n);
    n = 0;
    while (!irq_vec[ch] && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ticks land on the first edge after START, then every s+1 edges
  function automatic int nticks(input int e, input int s);
    return e >= 1 ? (e - 1) / (s + 1) + 1 : 0;
  endfunction

  // counter value after m ticks; a one-shot channel parks at its period after the timeout
  function automatic int unsigned mcnt(input int p, input int m, input bit cont);
    return cont ? p - (m % (p + 1)) : (m > p ? p : p - m);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int n, ch, p, s, k, m;
    bit cont, ito, to, run;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 0);
    check("rst_irq", 32'({irq_vec, irq}), 0);
    reset_n = 1'b1;
    @(negedge clk);
    rd(0, 2, 499, "ch0_period_rst");
    rd(0, 0, 0, "ch0_status_rst");
    rd(0, 1, 0, "ch0_ctrl_rst");
    rd(0, 3, 0, "ch0_snap_rst");
    rd(0, 4, 0, "ch0_pre_rst");

    wr(1, 2, 9);
    wr(1, 1, 'h7);
    wait_irq(1, 60, n);
    check("ch1_first_to", n, 1 + 9);
    wr(1, 0, 0);
    check("ch1_irq_clear", 32'({irq, irq_vec[1]}), 0);
    wait_irq(1, 60, n);
    check("ch1_second_to", n, 10 - 1);
    wr(1, 1, 'h8);
    wr(1, 0, 0);
    rd(1, 0, 0, "ch1_stopped");

    wr(2, 2, 3);
    wr(2, 4, 4);
    wr(2, 1, 'h5);
    wait_irq(2, 80, n);
    check("ch2_first_to", n, 1 + 3 * 5);
    rd(2, 0, 1, "ch2_oneshot_status");
    wr(2, 3, 0);
    rd(2, 3, 3, "ch2_snap_hold");
    rd(2, 1, 1, "ch2_ctrl_rb");
    rd(2, 4, 4, "ch2_pre_rb");
    rd(2, 5, 0, "ch2_rsvd5");
    rd(2, 7, 0, "ch2_rsvd7");

    wr(3, 2, 4);
    wr(3, 1, 'h7);
    repeat (4) @(negedge clk);
    wr(3, 0, 0);
    rd(3, 0, 3, "ch3_status_wr_on_to");
    wr(3, 1, 'h8);
    rd(3, 0, 1, "ch3_stop");
    wr(3, 1, 'hE);
    rd(3, 0, 3, "ch3_start_stop");
    wr(3, 2, 50);
    rd(3, 0, 1, "ch3_period_stops");
    wr(3, 3, 0);
    rd(3, 3, 50, "ch3_period_loads_cnt");

    wr(0, 2, 100);
    wr(0, 1, 'h6);
    repeat (39) @(negedge clk);
    wr(0, 3, 0);
    rd(0, 3, mcnt(100, nticks(39, 0), 1'b1), "ch0_snap_mid");
    repeat (8) @(negedge clk);
    wr(0, 3, 0);
    rd(0, 3, mcnt(100, nticks(49, 0), 1'b1), "ch0_snap_running");

    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_rst_readdata", readdata, 0);
    check("async_rst_irq", 32'({irq_vec, irq}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(0, 2, 499, "ch0_period_after_rst");
    rd(0, 0, 0, "ch0_status_after_rst");
    rd(2, 0, 0, "ch2_status_after_rst");
    rd(0, 3, 0, "ch0_snap_after_rst");

    for (int it = 0; it < 40; it++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      p = $urandom_range(0, 15);
      s = $urandom_range(0, 3);
      cont = 1'($urandom_range(0, 1));
      ito = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 60);
      wr(ch, 2, p);
      wr(ch, 4, s);
      wr(ch, 0, 0);
      wr(ch, 1, 32'(ito) | (32'(cont) << 1) | 32'h4);
      repeat (k) @(negedge clk);
      wr(ch, 3, 0);
      rd(ch, 3, mcnt(p, nticks(k, s), cont), $sformatf("rnd%0d_snap", it));
      m = nticks(k + 2, s);
      to = m > p;
      run = cont || m <= p;
      check($sformatf("rnd%0d_irq", it), 32'(irq_vec[ch]), 32'(to && ito));
      rd(ch, 0, 32'({run, to}), $sformatf("rnd%0d_status", it));
      rd(ch, 1, 32'(ito) | (32'(cont) << 1), $sformatf("rnd%0d_ctrl", it));
    end

`ifdef NIOS_MULTI_TIMER_CASCADE_EN
    wr(0, 4, 0);
    wr(0, 2, 1);
    wr(1, 2, 2);
    wr(1, 0, 0);
    wr(1, 1, 'h17);
    wr(0, 1, 'h16);
    rd(0, 1, 'h2, "casc_ch0_ignored");
    rd(1, 1, 'h13, "casc_ch1_ctrl");
    wait_irq(1, 60, n);
    check("casc_first_seen", 32'(n < 60), 1);
    for (int j = 0; j < 2; j++) begin
      wr(1, 0, 0);
      wait_irq(1, 60, n);
      check($sformatf("casc_interval%0d", j), n, 6 - 1);
    end
`else
    wr(1, 1, 'h10);
    rd(1, 1, 0, "casc_bit_absent");
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
